// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD seven-segment scan controller.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package bcd_pkg;

    typedef enum logic [1:0] {IDLE, LATCH, BLANK, DRIVE} state_t;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [7:0] AN_OFF   = 8'hFF;

    // Entries 0xA..0xF are not BCD and render as a dash.
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Bit k set means digit k is a leading zero to be blanked; digit 0 never is.
    function automatic logic [7:0] lz_mask(input logic [31:0] data, input logic lz_en);
        logic [7:0] mask;
        logic       above_zero;
        mask       = '0;
        above_zero = 1'b1;
        for (int k = 7; k >= 0; k--) begin
            above_zero = above_zero && (data[4*k +: 4] == 4'd0);
            mask[k]    = lz_en && (k != 0) && above_zero;
        end
        return mask;
    endfunction

endpackage

// File: rtl/bcd_scan_ctrl_bcd_to_7seg.sv
// Combinational BCD nibble to active-low seven-segment decoder.
import bcd_pkg::*;

module bcd_to_7seg (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Time-multiplexed 8-digit seven-segment scan controller with per-frame
// snapshot, blank gap between digits and optional leading-zero blanking.
import bcd_pkg::*;

module bcd_scan_ctrl #(
    parameter int N_DIGITS        = 8,
    parameter int TICKS_PER_DIGIT = 100000,
    parameter int BLANK_TICKS     = 1000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [31:0] data_i,
    input  logic [7:0]  dp_i,
    input  logic        blank_lz_i,
    output logic [7:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic        frame_o
);

    localparam int MAX_TICKS = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT : BLANK_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(TICKS_PER_DIGIT - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_TICKS > 0) ? CNT_W'(BLANK_TICKS - 1) : '0;
    localparam logic [2:0]       LAST_IDX   = 3'(N_DIGITS - 1);
    localparam state_t           AFTER_GAP  = (BLANK_TICKS > 0) ? BLANK : DRIVE;

    state_t           r_state;
    logic [2:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_data;
    logic [7:0]       r_dp;
    logic [7:0]       r_mask;
    logic [7:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp_out;
    logic             r_frame;

    state_t      w_state_next;
    logic [2:0]  w_idx_next;
    logic        w_slot_end;
    logic [31:0] w_data_eff;
    logic [7:0]  w_dp_eff;
    logic [7:0]  w_mask_eff;
    logic [6:0]  w_seg_dec;
    logic [7:0]  w_an_next;
    logic [6:0]  w_seg_next;
    logic        w_dp_next;
    logic        w_frame_next;

    // State register, counters, snapshot and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_data   <= '0;
            r_dp     <= '0;
            r_mask   <= '0;
            r_an     <= AN_OFF;
            r_seg    <= SEG_OFF;
            r_dp_out <= 1'b1;
            r_frame  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            if (w_slot_end || (w_state_next != r_state) || (w_state_next == IDLE) || (w_state_next == LATCH))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CNT_W'(1);
            if (r_state == LATCH) begin
                r_data <= data_i;
                r_dp   <= dp_i;
                r_mask <= lz_mask(data_i, blank_lz_i);
            end
            r_an     <= w_an_next;
            r_seg    <= w_seg_next;
            r_dp_out <= w_dp_next;
            r_frame  <= w_frame_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_slot_end   = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_next = LATCH;
                w_idx_next   = '0;
            end
            LATCH: begin
                w_state_next = AFTER_GAP;
                w_idx_next   = '0;
            end
            BLANK: begin
                if (r_cnt == BLANK_LAST) begin
                    w_slot_end   = 1'b1;
                    w_state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (r_cnt == DRIVE_LAST) begin
                    w_slot_end = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_state_next = LATCH;
                    end else begin
                        w_idx_next   = r_idx + 3'd1;
                        w_state_next = AFTER_GAP;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
        if (!en_i) begin
            w_state_next = IDLE;
            w_idx_next   = '0;
            w_slot_end   = 1'b0;
        end
    end

    // Outputs follow the next state; with no blank gap DRIVE can follow
    // LATCH directly, so the snapshot being captured is used as-is.
    assign w_data_eff = (r_state == LATCH) ? data_i : r_data;
    assign w_dp_eff   = (r_state == LATCH) ? dp_i : r_dp;
    assign w_mask_eff = (r_state == LATCH) ? lz_mask(data_i, blank_lz_i) : r_mask;

    bcd_to_7seg u_dec (
        .i_nibble (w_data_eff[4*w_idx_next +: 4]),
        .o_seg    (w_seg_dec)
    );

    always_comb begin
        w_an_next    = AN_OFF;
        w_seg_next   = SEG_OFF;
        w_dp_next    = 1'b1;
        w_frame_next = (w_state_next == LATCH);
        if ((w_state_next == DRIVE) && !w_mask_eff[w_idx_next]) begin
            w_an_next  = ~(8'd1 << w_idx_next);
            w_seg_next = w_seg_dec;
            w_dp_next  = ~w_dp_eff[w_idx_next];
        end
    end

    assign an_o    = r_an;
    assign seg_o   = r_seg;
    assign dp_o    = r_dp_out;
    assign frame_o = r_frame;

endmodule
